// File: rtl/seq_det101_sched.sv
// Round-robin scheduler sharing one serial "101" Mealy detector between two requesters.
// Define SEQ_DET_NOVLP_EN for non-overlapping detection; default is overlapping.
module seq_det101_sched #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req,
  input  logic [W-1:0]  data0,
  input  logic [W-1:0]  data1,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic          x_out,
  output logic          y_out,
  output logic [1:0]    done,
  output logic [CW-1:0] count
);

  localparam int unsigned BW = $clog2(W);
  localparam logic [BW-1:0] LastBit = BW'(W - 1);
  localparam logic [CW-1:0] CntMax  = '1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  localparam logic [1:0] DetS0 = 2'd0;
  localparam logic [1:0] DetS1 = 2'd1;
  localparam logic [1:0] DetS2 = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    det_q, det_d, det_nxt;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic          win;
  logic          in_shift;
  logic          first_bit;

  assign in_shift  = (state_q == StShift);
  assign first_bit = in_shift && (bit_cnt_q == '0);

  // Tie goes to whoever was not served last; reset value makes req0 win the first tie.
  assign win = (req == 2'b11) ? ~last_q : req[1];

  assign x_out = in_shift & shreg_q[W-1];
  assign y_out = in_shift && (det_q == DetS2) && x_out;
  assign busy  = (state_q == StShift) || (state_q == StDone);
  assign gnt   = first_bit ? {owner_q, ~owner_q} : 2'b00;
  assign done  = (state_q == StDone) ? {owner_q, ~owner_q} : 2'b00;
  assign count = count_q;

  always_comb begin
    det_nxt = DetS0;
    case (det_q)
      DetS0: det_nxt = x_out ? DetS1 : DetS0;
      DetS1: det_nxt = x_out ? DetS1 : DetS2;
      DetS2: begin
`ifdef SEQ_DET_NOVLP_EN
        det_nxt = DetS0;
`else
        det_nxt = x_out ? DetS1 : DetS0;
`endif
      end
      default: det_nxt = DetS0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    det_d     = det_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    owner_d   = owner_q;
    last_d    = last_q;
    case (state_q)
      StIdle: begin
        if (|req) begin
          owner_d   = win;
          shreg_d   = win ? data1 : data0;
          count_d   = '0;
          bit_cnt_d = '0;
          det_d     = DetS0;
          state_d   = StShift;
        end
      end
      StShift: begin
        shreg_d   = shreg_q << 1;
        det_d     = det_nxt;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (y_out && (count_q != CntMax)) begin
          count_d = count_q + CW'(1);
        end
        if (bit_cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone: begin
        // Words are independent: no detector history carries into the next one.
        det_d   = DetS0;
        last_d  = owner_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      det_q     <= DetS0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      count_q   <= '0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      det_q     <= det_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
    end
  end

endmodule
